// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU opcodes, branch condition codes and flag bit positions.
// Imported by the flag unit, its interface and the branch condition evaluator.
package cpu_pkg;

    localparam int FLAG_W   = 3;
    localparam int OPCODE_W = 4;
    localparam int COND_W   = 3;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [OPCODE_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [OPCODE_W-1:0] ALU_XOR    = 4'b0001;
    localparam logic [OPCODE_W-1:0] ALU_RED    = 4'b0010;
    localparam logic [OPCODE_W-1:0] ALU_SLL    = 4'b0011;
    localparam logic [OPCODE_W-1:0] ALU_SRA    = 4'b0100;
    localparam logic [OPCODE_W-1:0] ALU_ROR    = 4'b0101;
    localparam logic [OPCODE_W-1:0] ALU_PADDSB = 4'b0110;
    localparam logic [OPCODE_W-1:0] ALU_LLB    = 4'b0111;
    localparam logic [OPCODE_W-1:0] ALU_LHB    = 4'b1000;

    localparam logic [COND_W-1:0] COND_NE     = 3'b000;
    localparam logic [COND_W-1:0] COND_EQ     = 3'b001;
    localparam logic [COND_W-1:0] COND_GT     = 3'b010;
    localparam logic [COND_W-1:0] COND_LT     = 3'b011;
    localparam logic [COND_W-1:0] COND_GE     = 3'b100;
    localparam logic [COND_W-1:0] COND_LE     = 3'b101;
    localparam logic [COND_W-1:0] COND_OV     = 3'b110;
    localparam logic [COND_W-1:0] COND_UNCOND = 3'b111;

endpackage

// File: rtl/alu_flag_unit_if.sv
// ALU result/flag bus between the execute stage (master) and the flag unit (slave).
// No backpressure: every signal is sampled or produced in the cycle it is valid.
interface alu_flag_unit_if;
    import cpu_pkg::*;

    logic                alu_valid;
    logic [OPCODE_W-1:0] alu_op;
    logic                alu_binv;
    logic                alu_zero;
    logic                alu_ovfl;
    logic                alu_neg;
    logic                stall;
    logic                br_valid;
    logic [COND_W-1:0]   br_cond;
    logic                br_taken;
    logic [FLAG_W-1:0]   flags;
    logic                flag_save;
    logic                flag_restore;
    logic                shadow_valid;

    modport master (
        output alu_valid, alu_op, alu_binv, alu_zero, alu_ovfl, alu_neg,
        output stall, br_valid, br_cond, flag_save, flag_restore,
        input  br_taken, flags, shadow_valid
    );

    modport slave (
        input  alu_valid, alu_op, alu_binv, alu_zero, alu_ovfl, alu_neg,
        input  stall, br_valid, br_cond, flag_save, flag_restore,
        output br_taken, flags, shadow_valid
    );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition check of a {Z,V,N} flag vector; zero latency, no state.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [COND_W-1:0] br_cond,
    output logic              cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            COND_NE:     cond_true = ~flags[FLAG_Z];
            COND_EQ:     cond_true =  flags[FLAG_Z];
            COND_GT:     cond_true = ~flags[FLAG_Z] & ~flags[FLAG_N];
            COND_LT:     cond_true =  flags[FLAG_N];
            COND_GE:     cond_true =  flags[FLAG_Z] | (~flags[FLAG_Z] & ~flags[FLAG_N]);
            COND_LE:     cond_true =  flags[FLAG_N] | flags[FLAG_Z];
            COND_OV:     cond_true =  flags[FLAG_V];
            COND_UNCOND: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Architectural Z/V/N flag register with one-deep shadow and branch resolution; flags update 1 cycle
// after retire, stall freezes all state, br_taken is combinational. ALU_FLAG_FWD_EN: branch sees next-state flags.
module alu_flag_unit
    import cpu_pkg::*;
#(
    parameter int NUM_FLAGS = FLAG_W,
    parameter int OP_W      = OPCODE_W
) (
    input  logic             clk,
    input  logic             rst,
    alu_flag_unit_if.slave   bus
);

    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [NUM_FLAGS-1:0] shadow_q, shadow_d;
    logic                 shadow_valid_q, shadow_valid_d;
    logic [NUM_FLAGS-1:0] br_flags;
    logic [OP_W-1:0]      op;
    logic                 upd_en, save_en, restore_en;
    logic                 cond_true;
    logic                 unused_binv;

    // Add and subtract set flags identically, so the subtract qualifier is not needed here.
    assign unused_binv = bus.alu_binv;
    assign op          = bus.alu_op;
    assign upd_en      = bus.alu_valid & ~bus.stall;
    assign save_en     = bus.flag_save & ~bus.stall;
    assign restore_en  = bus.flag_restore & ~bus.stall & shadow_valid_q;

    always_comb begin
        flags_d        = flags_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;

        if (restore_en) begin
            flags_d = shadow_q;
        end else if (upd_en) begin
            case (op)
                ALU_ADD: begin
                    flags_d[FLAG_Z] = bus.alu_zero;
                    flags_d[FLAG_V] = bus.alu_ovfl;
                    flags_d[FLAG_N] = bus.alu_neg;
                end
                ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: flags_d[FLAG_Z] = bus.alu_zero;
                ALU_RED, ALU_PADDSB, ALU_LLB, ALU_LHB: ;
                default: ;
            endcase
        end

        // Save captures pre-update flags; save with restore therefore swaps the two copies.
        if (save_en) begin
            shadow_d       = flags_q;
            shadow_valid_d = 1'b1;
        end else if (restore_en) begin
            shadow_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q        <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

`ifdef ALU_FLAG_FWD_EN
    assign br_flags = flags_d;
`else
    assign br_flags = flags_q;
`endif

    branch_cond_eval u_cond (
        .flags     (br_flags),
        .br_cond   (bus.br_cond),
        .cond_true (cond_true)
    );

    assign bus.br_taken     = bus.br_valid & cond_true & ~rst;
    assign bus.flags        = flags_q;
    assign bus.shadow_valid = shadow_valid_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboarded bench for alu_flag_unit: expected {flags, shadow_valid} queued at drive, compared after the edge.
module tb_alu_flag_unit;
    import cpu_pkg::*;

`ifdef ALU_FLAG_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] sb[$];
    logic [2:0] m_flags = 3'b000, m_shadow = 3'b000, n_flags, n_shadow;
    logic       m_sv = 1'b0, n_sv;
    logic [3:0] exp_v;

    alu_flag_unit_if bus();

    alu_flag_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic cond_exp(input logic [2:0] f, input logic [2:0] c);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return ~z;
            3'd1:    return z;
            3'd2:    return ~z & ~n;
            3'd3:    return n;
            3'd4:    return z | (~z & ~n);
            3'd5:    return n | z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [3:0] op, input logic z, input logic o,
                          input logic n, input logic st, input logic sv, input logic rs);
        bus.alu_valid    = v;
        bus.alu_op       = op;
        bus.alu_binv     = op[0];
        bus.alu_zero     = z;
        bus.alu_ovfl     = o;
        bus.alu_neg      = n;
        bus.stall        = st;
        bus.flag_save    = sv;
        bus.flag_restore = rs;
        n_flags  = m_flags;
        n_shadow = m_shadow;
        n_sv     = m_sv;
        if (!st) begin
            if (rs && m_sv) n_flags = m_shadow;
            else if (v) begin
                if (op == 4'd0) n_flags = {z, o, n};
                else if (op inside {4'd1, 4'd3, 4'd4, 4'd5}) n_flags[2] = z;
            end
            if (sv) begin
                n_shadow = m_flags;
                n_sv     = 1'b1;
            end else if (rs && m_sv) begin
                n_sv = 1'b0;
            end
        end
        sb.push_back({n_flags, n_sv});
    endtask

    task automatic idle();
        bus.alu_valid    = 1'b0;
        bus.stall        = 1'b0;
        bus.flag_save    = 1'b0;
        bus.flag_restore = 1'b0;
    endtask

    task automatic set_br(input logic v, input logic [2:0] c);
        bus.br_valid = v;
        bus.br_cond  = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_flags  = n_flags;
        m_shadow = n_shadow;
        m_sv     = n_sv;
    endtask

    task automatic test_reset();
        idle();
        bus.alu_op = 4'd0; bus.alu_binv = 1'b0; bus.alu_zero = 1'b0;
        bus.alu_ovfl = 1'b0; bus.alu_neg = 1'b0;
        set_br(1'b1, 3'b000);
        #2;
        checks++;
        if (bus.flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", bus.flags); end
        checks++;
        if (bus.shadow_valid !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b expected 0", bus.shadow_valid); end
        checks++;
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL reset_br: got %b expected 0", bus.br_taken); end
        #8 rst = 1'b0;
        set_br(1'b0, 3'b000);
    endtask

    task automatic test_add_sub();
        set_in(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus.flags, bus.shadow_valid} !== exp_v || bus.flags !== 3'b011) begin
            errors++; $display("FAIL sub_flags: got %b expected %b", bus.flags, exp_v[3:1]);
        end
        idle();
        set_br(1'b1, 3'b110);
        #1;
        checks++;
        if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL br_ov: got %b expected 1", bus.br_taken); end
        set_br(1'b0, 3'b110);
        #1;
        checks++;
        if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL br_invalid: got %b expected 0", bus.br_taken); end
    endtask

    task automatic test_z_only();
        logic [3:0] ops[6]  = '{4'd1, 4'd7, 4'd4, 4'd8, 4'd15, 4'd2};
        logic [2:0] zon[6]  = '{3'b100, 3'b101, 3'b011, 3'b111, 3'b111, 3'b100};
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, ops[i], zon[i][2], zon[i][1], zon[i][0], 1'b0, 1'b0, 1'b0);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({bus.flags, bus.shadow_valid} !== exp_v) begin
                errors++; $display("FAIL zonly_op%0d: got %b expected %b", ops[i], bus.flags, exp_v[3:1]);
            end
            if (i == 0) begin
                checks++;
                if (bus.flags !== 3'b111) begin errors++; $display("FAIL xor_z: got %b expected 111", bus.flags); end
            end
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        set_br(1'b1, 3'b111);
        #1;
        checks++;
        if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL stall_br: got %b expected 1", bus.br_taken); end
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus.flags, bus.shadow_valid} !== exp_v || bus.flags !== 3'b011) begin
            errors++; $display("FAIL stall_hold: got %b/%b expected %b", bus.flags, bus.shadow_valid, exp_v);
        end
        set_br(1'b0, 3'b000);
        idle();
    endtask

    task automatic test_save_restore();
        // Each row: valid, op-add, z, o, n, save, restore
        logic [6:0] seq[7] = '{7'b1_0_100_00, 7'b0_0_000_10, 7'b1_0_001_00, 7'b1_0_010_01,
                               7'b0_0_000_01, 7'b1_0_011_10, 7'b0_0_000_01};
        for (int i = 0; i < 7; i++) begin
            set_in(seq[i][6], 4'd0, seq[i][4], seq[i][3], seq[i][2], 1'b0, seq[i][1], seq[i][0]);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({bus.flags, bus.shadow_valid} !== exp_v) begin
                errors++; $display("FAIL save_restore_%0d: got %b/%b expected %b", i, bus.flags, bus.shadow_valid, exp_v);
            end
            if (i == 3 || i == 4) begin
                checks++;
                if (bus.flags !== 3'b100 || bus.shadow_valid !== 1'b0) begin
                    errors++; $display("FAIL restore_%0d: got %b/%b expected 100/0", i, bus.flags, bus.shadow_valid);
                end
            end
        end
        idle();
    endtask

    task automatic test_swap();
        // flags 100 -> save; update to 010; save+restore swaps; restore returns to 010
        logic [6:0] seq[4] = '{7'b0_0_000_10, 7'b1_0_010_00, 7'b0_0_000_11, 7'b0_0_000_01};
        for (int i = 0; i < 4; i++) begin
            set_in(seq[i][6], 4'd0, seq[i][4], seq[i][3], seq[i][2], 1'b0, seq[i][1], seq[i][0]);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({bus.flags, bus.shadow_valid} !== exp_v) begin
                errors++; $display("FAIL swap_%0d: got %b/%b expected %b", i, bus.flags, bus.shadow_valid, exp_v);
            end
        end
        idle();
    endtask

    task automatic test_branch_table();
        logic [2:0] fb;
        for (int f = 0; f < 8; f++) begin
            fb = f[2:0];
            set_in(1'b1, 4'd0, fb[2], fb[1], fb[0], 1'b0, 1'b0, 1'b0);
            tick();
            exp_v = sb.pop_front();
            checks++;
            if ({bus.flags, bus.shadow_valid} !== exp_v) begin
                errors++; $display("FAIL br_setup_%0d: got %b expected %b", f, bus.flags, exp_v[3:1]);
            end
            idle();
            for (int c = 0; c < 8; c++) begin
                set_br(1'b1, c[2:0]);
                #1;
                checks++;
                if (bus.br_taken !== cond_exp(m_flags, c[2:0])) begin
                    errors++; $display("FAIL br_cond%0d_f%b: got %b expected %b", c, m_flags, bus.br_taken, cond_exp(m_flags, c[2:0]));
                end
            end
            set_br(1'b0, 3'b111);
        end
    endtask

    task automatic test_forward();
        set_in(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus.flags, bus.shadow_valid} !== exp_v) begin
            errors++; $display("FAIL fwd_setup: got %b expected %b", bus.flags, exp_v[3:1]);
        end
        set_in(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_br(1'b1, 3'b001);
        #1;
        checks++;
        if (bus.br_taken !== FWD) begin errors++; $display("FAIL fwd_eq: got %b expected %b", bus.br_taken, FWD); end
        tick();
        exp_v = sb.pop_front();
        idle();
        #1;
        checks++;
        if ({bus.flags, bus.shadow_valid} !== exp_v || bus.br_taken !== 1'b1) begin
            errors++; $display("FAIL fwd_after: got %b br %b expected %b br 1", bus.flags, bus.br_taken, exp_v[3:1]);
        end
        set_br(1'b0, 3'b000);
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exp_v = sb.pop_front();
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus.flags, bus.shadow_valid} !== 4'b1111) begin
            errors++; $display("FAIL arst_setup: got %b/%b expected 111/1", bus.flags, bus.shadow_valid);
        end
        idle();
        set_br(1'b1, 3'b000);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.flags !== 3'b000 || bus.shadow_valid !== 1'b0 || bus.br_taken !== 1'b0) begin
            errors++; $display("FAIL arst_mid: got %b/%b br %b expected 000/0 br 0", bus.flags, bus.shadow_valid, bus.br_taken);
        end
        #2 rst = 1'b0;
        m_flags = 3'b000; m_shadow = 3'b000; m_sv = 1'b0;
        set_br(1'b0, 3'b000);
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        exp_v = sb.pop_front();
        checks++;
        if ({bus.flags, bus.shadow_valid} !== exp_v) begin
            errors++; $display("FAIL arst_restore: got %b/%b expected %b", bus.flags, bus.shadow_valid, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_z_only();
        test_stall();
        test_save_restore();
        test_swap();
        test_branch_table();
        test_forward();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Consumer end of the ALU result/flag interface.
- Latches the ALU's zero/overflow/negative outputs into the architectural flag register (Z, V, N), following per-opcode update rules.
- Evaluates 3-bit branch condition codes against the flags and drives branch_taken to the PC logic.
- Holds a one-deep shadow copy of the flags for exception save/restore.

Parameters:
- NUM_FLAGS, 3, width of the flag vector {Z,V,N}; fixed by the ISA and not overridable in practice.
- OP_W, 4, width of the ALU opcode field.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  an ALU instruction retires this cycle (not squashed)
- alu_op  input  4  ALU opcode (0000 add/sub, 0001 xor, 0010 red, 0011 sll, 0100 sra, 0101 ror, 0110 paddsb, 0111 llb, 1000 lhb)
- alu_binv  input  1  subtract qualifier for op 0000
- alu_zero  input  1  ALU zero output
- alu_ovfl  input  1  ALU overflow output
- alu_neg  input  1  ALU negative output
- stall  input  1  pipeline hold; freezes all state
- br_valid  input  1  a conditional branch is evaluated this cycle
- br_cond  input  3  condition code
- br_taken  output  1  branch resolves taken
- flags  output  3  registered flags {Z,V,N}
- flag_save  input  1  copy flags into the shadow register
- flag_restore  input  1  load flags from the shadow register
- shadow_valid  output  1  shadow register holds a saved value

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - flags = 3'b000, shadow = 3'b000, shadow_valid = 0.
  - br_taken is combinational; while rst is high it is 0.
- Update rules, when alu_valid=1 and stall=0:
  - Op 0000: writes Z, V, N from alu_zero, alu_ovfl, alu_neg. This applies for both add and sub.
  - Ops 0001, 0011, 0100, 0101: write Z only; V and N hold.
  - Ops 0010, 0110, 0111, 0100x (1000) and undefined ops 1001–1111: flags hold.
- Latency: flags output reflects the update 1 cycle after the retiring cycle.
- Priority within a cycle: rst > stall > flag_restore > ALU update.
  - restore + alu_valid in the same cycle: the restored value wins and the ALU update is dropped.
- Save:
  - flag_save=1 and stall=0 loads the shadow from the current registered flags (pre-update value, even if an update lands the same cycle).
  - shadow_valid is set to 1.
- Restore:
  - flag_restore=1 and stall=0 with shadow_valid=1: flags ← shadow, shadow_valid ← 0.
  - Restore with shadow_valid=0: ignored, flags unchanged.
- Simultaneous save + restore: restore takes effect on flags; the shadow is reloaded with the pre-restore flags and shadow_valid stays 1 (swap).
- Branch conditions (combinational from the flag source). br_taken = br_valid & cond, with cond by br_cond:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- br_valid=0 forces br_taken=0. stall does not gate br_taken; the consumer qualifies it.

Optional Feature:
- Macro: ALU_FLAG_FWD_EN.
- Defined: the branch evaluator uses next-state flags, i.e. the same-cycle ALU update (restore-aware) is bypassed combinationally. A branch in the same cycle as a flag-setting op sees the new flags.
- Undefined: the branch evaluator uses registered flags only; the pipeline must separate the flag-setting op and the dependent branch by at least 1 cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode localparams (ALU_ADD=4'b0000 … ALU_LHB=4'b1000).
  - Condition-code localparams (COND_NE … COND_UNCOND).
  - Flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0).
- One natural sub-module: branch_cond_eval, purely combinational (flags[2:0], br_cond → cond_true). It is reused by the branch unit.

Test Plan:
- rst pulsed mid-cycle with flags=3'b111 and shadow_valid=1 → flags=000 and shadow_valid=0 immediately, without waiting for a clock edge.
- alu_op=0000, binv=1, zero=0, ovfl=1, neg=1, alu_valid=1 → next cycle flags=3'b011; then br_cond=110, br_valid=1 → br_taken=1.
- flags=3'b011, then alu_op=0001 with zero=1, ovfl=0, neg=0 → flags=3'b111 (only Z written); alu_op=0111 → flags unchanged.
- stall=1 with alu_valid=1 and op=0000 → flags hold. br_cond=111 with br_valid=1 → br_taken=1 regardless of the stall.
- Save with flags=3'b100, update to 3'b001, then restore + alu_valid (op 0000) in the same cycle → flags=3'b100 and shadow_valid=0; a second restore → ignored.
- Define ALU_FLAG_FWD_EN; op 0000 with zero=1 plus br_cond=001 in the same cycle, with prior Z=0 → br_taken=1. Without the macro → br_taken=0.
